// File: rtl/decision_sequencer.sv
// decision_sequencer: run-control FSM for the blink-decision counter and LED display.
// Each round clears the counter, gates blinky into it for one counting window, latches
// the answer (or TIMEOUT_CODE on expiry), shows it for SHOW_CYCLES and then goes idle.
// Optional feature macro: DECISION_AUTO_REARM_EN -- when defined, SHOW expiry re-arms
// straight into CLEAR so rounds run back to back after a single start.
module decision_sequencer #(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         SHOW_CYCLES    = 50000000,
  parameter int         TMR_W          = 26,
  parameter logic [2:0] TIMEOUT_CODE   = 3'b111
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_blinky,
  input  logic       i_cnt_done,
  input  logic [2:0] i_cnt_answer,
  output logic       o_cnt_clr,
  output logic       o_cnt_en,
  output logic       o_blink_gated,
  output logic [2:0] o_led_out,
  output logic       o_result_valid,
  output logic       o_timed_out,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_COUNT = 2'b10,
    ST_SHOW  = 2'b11
  } state_t;

  localparam logic [TMR_W-1:0] TMR_ZERO      = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE       = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] TMR_TO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [2:0]       r_led;
  logic             r_timed_out;
  logic             r_result_valid;
  logic             r_cnt_clr;
  logic             r_cnt_en;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [TMR_W-1:0] w_timer_nxt;
  logic [2:0]       w_led_nxt;
  logic             w_timed_out_nxt;
  logic             w_result_valid_nxt;

  // Next-state, timer and result logic; abort overrides everything while a round runs.
  always_comb begin
    w_state_nxt        = r_state;
    w_timer_nxt        = r_timer;
    w_led_nxt          = r_led;
    w_timed_out_nxt    = r_timed_out;
    w_result_valid_nxt = 1'b0;
    if (i_abort && (r_state != ST_IDLE)) begin
      w_state_nxt     = ST_IDLE;
      w_timer_nxt     = TMR_ZERO;
      w_led_nxt       = 3'b000;
      w_timed_out_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_timer_nxt     = TMR_ZERO;
          w_led_nxt       = 3'b000;
          w_timed_out_nxt = 1'b0;
          if (i_start && !i_abort) begin
            w_state_nxt = ST_CLEAR;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          w_timer_nxt = TMR_ZERO;
          w_state_nxt = ST_COUNT;
        end
        ST_COUNT: begin
          if (i_cnt_done) begin
            // A real answer beats a timeout landing on the same cycle.
            w_led_nxt          = i_cnt_answer;
            w_timed_out_nxt    = 1'b0;
            w_result_valid_nxt = 1'b1;
            w_timer_nxt        = TMR_ZERO;
            w_state_nxt        = ST_SHOW;
          end else if (r_timer == TMR_TO_LAST) begin
            w_led_nxt          = TIMEOUT_CODE;
            w_timed_out_nxt    = 1'b1;
            w_result_valid_nxt = 1'b1;
            w_timer_nxt        = TMR_ZERO;
            w_state_nxt        = ST_SHOW;
          end else begin
            w_timer_nxt = r_timer + TMR_ONE;
          end
        end
        ST_SHOW: begin
          if (r_timer == TMR_SHOW_LAST) begin
            w_led_nxt       = 3'b000;
            w_timed_out_nxt = 1'b0;
            w_timer_nxt     = TMR_ZERO;
`ifdef DECISION_AUTO_REARM_EN
            w_state_nxt     = ST_CLEAR;
`else
            w_state_nxt     = ST_IDLE;
`endif
          end else begin
            w_timer_nxt = r_timer + TMR_ONE;
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_timer_nxt     = TMR_ZERO;
          w_led_nxt       = 3'b000;
          w_timed_out_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and timer register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= TMR_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Registered outputs, decoded from the next state so they line up with the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_led          <= 3'b000;
      r_timed_out    <= 1'b0;
      r_result_valid <= 1'b0;
      r_cnt_clr      <= 1'b0;
      r_cnt_en       <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_led          <= w_led_nxt;
      r_timed_out    <= w_timed_out_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_cnt_clr      <= (w_state_nxt == ST_CLEAR);
      r_cnt_en       <= (w_state_nxt == ST_COUNT);
      r_busy         <= (w_state_nxt != ST_IDLE);
    end
  end

  assign o_blink_gated  = i_blinky & (r_state == ST_COUNT);
  assign o_led_out      = r_led;
  assign o_timed_out    = r_timed_out;
  assign o_result_valid = r_result_valid;
  assign o_cnt_clr      = r_cnt_clr;
  assign o_cnt_en       = r_cnt_en;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_decision_sequencer.sv
// Scoreboard bench for decision_sequencer (TIMEOUT_CYCLES=20, SHOW_CYCLES=8).
module tb_decision_sequencer;

  localparam int TO_C = 20;
  localparam int SH_C = 8;

  logic       clk = 1'b0;
  logic       i_rst_n, i_start, i_abort, i_blinky, i_cnt_done;
  logic [2:0] i_cnt_answer;
  logic       o_cnt_clr, o_cnt_en, o_blink_gated, o_result_valid, o_timed_out, o_busy;
  logic [2:0] o_led_out;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];      // {timed_out, led_out} expected at each result_valid
  bit         sb_free  = 1'b0;

  decision_sequencer #(
    .TIMEOUT_CYCLES(TO_C),
    .SHOW_CYCLES   (SH_C),
    .TMR_W         (5),
    .TIMEOUT_CODE  (3'b111)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_blinky      (i_blinky),
    .i_cnt_done    (i_cnt_done),
    .i_cnt_answer  (i_cnt_answer),
    .o_cnt_clr     (o_cnt_clr),
    .o_cnt_en      (o_cnt_en),
    .o_blink_gated (o_blink_gated),
    .o_led_out     (o_led_out),
    .o_result_valid(o_result_valid),
    .o_timed_out   (o_timed_out),
    .o_busy        (o_busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every result_valid pulse consumes one scoreboard entry.
  always @(negedge clk) begin : mon
    logic [3:0] e;
    if (o_result_valid === 1'b1) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", {28'd0, o_timed_out, o_led_out}, {28'd0, e});
      end else if (sb_free) begin
        chk("result_rearm", {28'd0, o_timed_out, o_led_out}, 32'h0000_000F);
      end else begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got led=%0h timed_out=%0b expected no result_valid",
                 o_led_out, o_timed_out);
      end
    end
  end

  // Global time limit.
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // Issue start, check the CLEAR pulse, end on the first COUNT cycle.
  task automatic start_round;
    i_start = 1'b1;
    tick;
    chk("clr_pulse", o_cnt_clr, 1);
    chk("busy_clear", o_busy, 1);
    i_start = 1'b0;
    tick;
    chk("clr_one_cycle", o_cnt_clr, 0);
    chk("cnt_en_count", o_cnt_en, 1);
  endtask

  // Wait (bounded) for result_valid, counting cnt_en cycles.
  task automatic wait_rv(output int cnt);
    int guard;
    cnt   = 0;
    guard = 0;
    while (o_result_valid !== 1'b1 && guard < 100) begin
      if (o_cnt_en === 1'b1) cnt++;
      tick;
      guard++;
    end
    chk("rv_seen", o_result_valid, 1);
  endtask

  // Measure how many samples led_out holds v, then check the round ended cleanly.
  task automatic show_and_end(input logic [2:0] v);
    int n;
    n = 0;
    while (o_led_out === v && n < 64) begin
      n++;
      tick;
    end
    chk("show_len", n, SH_C);
    chk("led_cleared", o_led_out, 0);
    chk("to_cleared", o_timed_out, 0);
`ifdef DECISION_AUTO_REARM_EN
    chk("rearm_clr", o_cnt_clr, 1);
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
`endif
    chk("busy_end", o_busy, 0);
  endtask

  initial begin
    int cnt;
    int clr_cnt;
    i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_blinky = 1'b0;
    i_cnt_done = 1'b0; i_cnt_answer = 3'b000;

    // 1: reset, blinky toggling
    for (int i = 0; i < 3; i++) begin
      i_blinky = ~i_blinky;
      tick;
      chk("rst_outputs", {25'd0, o_cnt_clr, o_cnt_en, o_led_out, o_result_valid, o_timed_out}, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_blink_gated", o_blink_gated, 0);
    end
    i_rst_n  = 1'b1;
    i_blinky = 1'b0;
    tick;
    chk("idle_busy", o_busy, 0);

    // 2: done with 101 on the 5th COUNT cycle
    exp_q.push_back({1'b0, 3'b101});
    start_round;
    i_blinky = 1'b1;
    #1;
    chk("blink_gated_count", o_blink_gated, 1);
    repeat (4) tick;
    i_cnt_done = 1'b1; i_cnt_answer = 3'b101;
    tick;
    i_cnt_done = 1'b0; i_blinky = 1'b0;
    chk("done_led", o_led_out, 3'b101);
    chk("done_rv", o_result_valid, 1);
    chk("done_to", o_timed_out, 0);
    chk("show_en", o_cnt_en, 0);
    show_and_end(3'b101);
    // cnt_done while idle is ignored
    i_cnt_done = 1'b1; i_cnt_answer = 3'b011; i_blinky = 1'b1;
    tick;
    chk("idle_blink_gated", o_blink_gated, 0);
    tick;
    i_cnt_done = 1'b0; i_blinky = 1'b0;
    chk("idle_done_ignored", {29'd0, o_busy, o_led_out != 3'b000, o_result_valid}, 0);

    // 3: timeout after 20 COUNT cycles
    exp_q.push_back({1'b1, 3'b111});
    start_round;
    wait_rv(cnt);
    chk("timeout_cycles", cnt, TO_C);
    chk("timeout_led", o_led_out, 3'b111);
    chk("timeout_flag", o_timed_out, 1);
    show_and_end(3'b111);

    // 4: done on timer==19 wins over timeout
    exp_q.push_back({1'b0, 3'b010});
    start_round;
    repeat (TO_C - 1) tick;
    i_cnt_done = 1'b1; i_cnt_answer = 3'b010;
    tick;
    i_cnt_done = 1'b0;
    chk("tie_led", o_led_out, 3'b010);
    chk("tie_to", o_timed_out, 0);
    show_and_end(3'b010);

    // 5a: abort mid-COUNT
    start_round;
    repeat (5) tick;
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    chk("abort_cnt_state", {29'd0, o_busy, o_cnt_en, o_led_out != 3'b000}, 0);
    repeat (3) tick;
    chk("abort_cnt_idle", o_busy, 0);

    // 5b: start during SHOW ignored, then abort mid-SHOW of a timeout
    exp_q.push_back({1'b1, 3'b111});
    start_round;
    wait_rv(cnt);
    tick;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk("show_start_ignored_led", o_led_out, 3'b111);
    chk("show_start_ignored_clr", o_cnt_clr, 0);
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    chk("abort_show_led", o_led_out, 0);
    chk("abort_show_to", o_timed_out, 0);
    chk("abort_show_busy", o_busy, 0);
    clr_cnt = 0;
    repeat (5) begin
      tick;
      if (o_cnt_clr === 1'b1 || o_busy === 1'b1) clr_cnt++;
    end
    chk("no_queued_round", clr_cnt, 0);

    // 5c: abort beats done in the same cycle
    start_round;
    i_cnt_done = 1'b1; i_cnt_answer = 3'b110; i_abort = 1'b1;
    tick;
    i_cnt_done = 1'b0; i_abort = 1'b0;
    chk("abort_vs_done", {28'd0, o_busy, o_led_out}, 0);

    // 5d: reset mid-COUNT
    start_round;
    repeat (3) tick;
    i_rst_n = 1'b0;
    tick;
    chk("midrst_outputs", {24'd0, o_busy, o_cnt_clr, o_cnt_en, o_led_out, o_result_valid, o_timed_out}, 0);
    i_rst_n = 1'b1;
    tick;
    chk("midrst_idle", o_busy, 0);

    // 6: single start, count CLEAR pulses over 70 cycles
    sb_free = 1'b1;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    clr_cnt = (o_cnt_clr === 1'b1) ? 1 : 0;
    repeat (69) begin
      tick;
      if (o_cnt_clr === 1'b1) clr_cnt++;
    end
`ifdef DECISION_AUTO_REARM_EN
    chk("rearm_clr_count", clr_cnt, 3);
`else
    chk("single_clr_count", clr_cnt, 1);
`endif
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    tick;
    sb_free = 1'b0;
    chk("final_idle", o_busy, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
